vga_pattern_sequencer: RTL and testbench
========================================

// Module: vga_pattern_sequencer
// PURPOSE
//   Sequences test patterns for the VGA monitor datapath. Sits between
//   vga_controller (hsync/vsync/video_on/horizontal_num) and the DAC
//   outputs (VGA_R/G/B). Selects one of four patterns, auto-advancing
//   every FRAMES_PER_PATTERN frames or on a manual request. Changes take
//   effect only at a vsync boundary, so no frame shows two patterns.
// PARAMETERS
//   H_ACTIVE            640  visible pixels per line; bar width = H_ACTIVE/4
//   FRAMES_PER_PATTERN  60   frames per pattern in auto mode (>=1)
//   COLOR_W             8    width of each colour channel
// PORTS
//   clk_25          in   1        25 MHz pixel clock
//   rst             in   1        async reset, active-high
//   vsync           in   1        vertical sync from vga_controller, active-low
//   video_on        in   1        high during visible pixels
//   horizontal_num  in   10       current pixel column, 0..H_ACTIVE-1 when visible
//   hold            in   1        1 = freeze auto-advance (frame counter stops)
//   adv_req         in   1        manual advance request (level; 4-phase with adv_ack)
//   adv_ack         out  1        manual advance applied (see handshake)
//   pattern_sel     out  2        currently displayed pattern, 0..3
//   red/green/blue  out  COLOR_W  pixel colour to DAC
// BEHAVIOUR
//   Reset (async, rst=1): pattern_sel=0, frame_cnt=0, state=RUN,
//     adv_ack=0, red/green/blue=0, vsync_q=1 (idle-high sync).
//   Frame edge: fe = vsync_q & ~vsync (registered falling edge); one
//     fe per frame, detected 1 cycle after vsync falls.
//   FSM states RUN, PEND, ACK:
//     RUN : fe & ~hold -> frame_cnt++; at frame_cnt==FRAMES_PER_PATTERN-1
//           advance pattern, frame_cnt=0. fe & hold -> no change.
//           adv_req=1 -> PEND (frame counting continues).
//     PEND: on fe -> advance pattern, frame_cnt=0, adv_ack=1, -> ACK.
//           hold does not block a manual advance.
//     ACK : adv_ack stays 1 until adv_req=0; then adv_ack=0 next
//           cycle, -> RUN. Further fe in ACK follow RUN auto rules.
//   Advance: pattern_sel = pattern_sel+1, wraps 3 -> 0.
//   Auto and manual coinciding on the same fe: exactly one increment.
//   adv_req dropped in PEND before fe: request still served (latched).
//   Pixel path, registered, latency 1 cycle from video_on/horizontal_num:
//     video_on=0          -> RGB = 0 (all channels)
//     pattern 0 (bars)    -> col<H/4 red, <H/2 green, <3H/4 blue, else white
//     pattern 1 (white)   -> all channels all-ones
//     pattern 2 (ramp)    -> red=green=blue = horizontal_num[9 -: COLOR_W]
//     pattern 3 (checker) -> white if horizontal_num[5]^frame_cnt[0], else 0
//   pattern_sel changes on the cycle after fe, inside vertical blanking,
//     so the visible frame is uniform.
//   Reset mid-frame or mid-handshake: immediate return to reset values;
//     a pending request is discarded.
// TESTING
//   1 Reset: rst=1 mid-line with video_on=1 -> RGB=0, pattern_sel=0,
//     adv_ack=0 immediately, with no clock edge needed.
//   2 Auto: FRAMES_PER_PATTERN=3, hold=0, 13 vsync pulses -> pattern_sel
//     steps 0->1 on the 3rd fe, ->2 on the 6th, ->3 on the 9th, ->0 on
//     the 12th; unchanged after the 13th.
//   3 Hold: hold=1 for 10 frames -> pattern_sel constant, frame_cnt
//     frozen; release -> resumes counting from the held value.
//   4 Manual: adv_req=1 mid-frame -> no change until next fe; then
//     pattern_sel+1, adv_ack=1; adv_req=0 -> adv_ack=0 one cycle later.
//   5 Collision: manual request pending at the fe that also ends the auto
//     period -> pattern_sel increases by exactly 1, frame_cnt=0.
//   6 Pixels, pattern 0, H_ACTIVE=640: col 0 -> (FF,00,00), 160 -> (00,FF,00),
//     320 -> (00,00,FF), 639 -> (FF,FF,FF), each 1 cycle later;
//     video_on=0 -> (00,00,00).

Source files
------------

// File: rtl/vga_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// vga_pattern_sequencer
//   Chooses one of four VGA test patterns and renders it one pixel per clock.
//   The pattern advances automatically every FRAMES_PER_PATTERN frames, or
//   through a manual 4-phase request/acknowledge handshake. Every pattern
//   change happens on a vsync falling edge, so a visible frame never shows
//   two patterns.
//
// Ports
//   clk_25          pixel clock
//   rst             asynchronous reset, active-high
//   vsync           vertical sync, active-low
//   video_on        high while the current pixel is visible
//   horizontal_num  current pixel column
//   hold            1 = stop the automatic frame counter
//   adv_req         manual advance request (level)
//   adv_ack         manual advance has been applied
//   pattern_sel     pattern currently displayed (0..3)
//   red/green/blue  registered pixel colour, one cycle after the inputs
// ---------------------------------------------------------------------------
module vga_pattern_sequencer #(
    parameter int H_ACTIVE           = 640,
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int COLOR_W            = 8
) (
    input  logic               clk_25,
    input  logic               rst,
    input  logic               vsync,
    input  logic               video_on,
    input  logic [9:0]         horizontal_num,
    input  logic               hold,
    input  logic               adv_req,
    output logic               adv_ack,
    output logic [1:0]         pattern_sel,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);

    // A one-frame period still needs a 1-bit counter.
    localparam int CNT_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);

    localparam logic [9:0] BAR1 = 10'(H_ACTIVE / 4);
    localparam logic [9:0] BAR2 = 10'(H_ACTIVE / 2);
    localparam logic [9:0] BAR3 = 10'((3 * H_ACTIVE) / 4);

    localparam logic [COLOR_W-1:0] ONES  = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0] ZEROS = '0;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               vsync_q;
    logic               fe;
    logic [1:0]         pattern_reg, pattern_next;
    logic [CNT_W-1:0]   frame_cnt_reg, frame_cnt_next;
    logic [COLOR_W-1:0] red_reg, green_reg, blue_reg;
    logic [COLOR_W-1:0] red_next, green_next, blue_next;

    // Falling edge of the active-low vsync; vsync_q idles high so the
    // first frame after reset is detected normally.
    assign fe = vsync_q & ~vsync;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // The request is latched by entering PEND, so dropping adv_req there
    // does not cancel it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (adv_req) state_next = PEND;
            PEND:    if (fe)      state_next = ACK;
            ACK:     if (!adv_req) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        adv_ack = (state_reg == ACK);
    end

    // ---------------- pattern / frame counter ----------------
    // Manual and automatic advances landing on the same frame edge are
    // merged into a single increment.
    always_comb begin
        pattern_next   = pattern_reg;
        frame_cnt_next = frame_cnt_reg;
        if (fe) begin
            if ((state_reg == PEND) || (!hold && (frame_cnt_reg == CNT_LAST))) begin
                pattern_next   = pattern_reg + 2'd1;
                frame_cnt_next = '0;
            end else if (!hold) begin
                frame_cnt_next = frame_cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            vsync_q       <= 1'b1;
            pattern_reg   <= 2'd0;
            frame_cnt_reg <= '0;
        end else begin
            vsync_q       <= vsync;
            pattern_reg   <= pattern_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    // ---------------- pixel path ----------------
    always_comb begin
        red_next   = ZEROS;
        green_next = ZEROS;
        blue_next  = ZEROS;
        if (video_on) begin
            case (pattern_reg)
                2'd0: begin
                    if (horizontal_num < BAR1) begin
                        red_next = ONES;
                    end else if (horizontal_num < BAR2) begin
                        green_next = ONES;
                    end else if (horizontal_num < BAR3) begin
                        blue_next = ONES;
                    end else begin
                        red_next   = ONES;
                        green_next = ONES;
                        blue_next  = ONES;
                    end
                end
                2'd1: begin
                    red_next   = ONES;
                    green_next = ONES;
                    blue_next  = ONES;
                end
                2'd2: begin
                    red_next   = horizontal_num[9 -: COLOR_W];
                    green_next = horizontal_num[9 -: COLOR_W];
                    blue_next  = horizontal_num[9 -: COLOR_W];
                end
                default: begin
                    // Checker phase flips every frame via the counter LSB.
                    if (horizontal_num[5] ^ frame_cnt_reg[0]) begin
                        red_next   = ONES;
                        green_next = ONES;
                        blue_next  = ONES;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            red_reg   <= '0;
            green_reg <= '0;
            blue_reg  <= '0;
        end else begin
            red_reg   <= red_next;
            green_reg <= green_next;
            blue_reg  <= blue_next;
        end
    end

    assign pattern_sel = pattern_reg;
    assign red         = red_reg;
    assign green       = green_reg;
    assign blue        = blue_reg;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vga_pattern_sequencer
//   Directed bench for vga_pattern_sequencer with FRAMES_PER_PATTERN=3 and
//   H_ACTIVE=640. Expected values are written out by hand.
// ---------------------------------------------------------------------------
module tb_vga_pattern_sequencer;

    logic       clk_25 = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b1;
    logic       video_on = 1'b0;
    logic [9:0] horizontal_num = '0;
    logic       hold = 1'b0;
    logic       adv_req = 1'b0;
    logic       adv_ack;
    logic [1:0] pattern_sel;
    logic [7:0] red, green, blue;

    int checks = 0;
    int failures = 0;

    vga_pattern_sequencer #(
        .H_ACTIVE(640),
        .FRAMES_PER_PATTERN(3),
        .COLOR_W(8)
    ) dut (
        .clk_25(clk_25),
        .rst(rst),
        .vsync(vsync),
        .video_on(video_on),
        .horizontal_num(horizontal_num),
        .hold(hold),
        .adv_req(adv_req),
        .adv_ack(adv_ack),
        .pattern_sel(pattern_sel),
        .red(red),
        .green(green),
        .blue(blue)
    );

    always #5 clk_25 = ~clk_25;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // One vsync pulse: one frame edge.
    task automatic frame_pulse();
        @(negedge clk_25) vsync = 1'b0;
        repeat (4) @(negedge clk_25);
        vsync = 1'b1;
        repeat (4) @(negedge clk_25);
    endtask

    // Drive a pixel, then check the registered colour one cycle later.
    task automatic pix(input string tag, input logic von, input logic [9:0] col,
                       input logic [23:0] exp);
        @(negedge clk_25);
        video_on = von;
        horizontal_num = col;
        @(negedge clk_25);
        check_val(tag, {8'h0, red, green, blue}, {8'h0, exp});
    endtask

    initial begin
        // ---- reset state ----
        repeat (3) @(negedge clk_25);
        rst = 1'b0;
        @(negedge clk_25);
        check_val("rst_pattern", {30'd0, pattern_sel}, 32'd0);
        check_val("rst_ack", {31'd0, adv_ack}, 32'd0);
        check_val("rst_rgb", {8'h0, red, green, blue}, 32'd0);

        // ---- pattern 0 colour bars ----
        pix("bars_col0",   1'b1, 10'd0,   24'hFF0000);
        pix("bars_col159", 1'b1, 10'd159, 24'hFF0000);
        pix("bars_col160", 1'b1, 10'd160, 24'h00FF00);
        pix("bars_col320", 1'b1, 10'd320, 24'h0000FF);
        pix("bars_col639", 1'b1, 10'd639, 24'hFFFFFF);
        pix("bars_blank",  1'b0, 10'd639, 24'h000000);

        // ---- auto advance: 13 frames ----
        for (int n = 1; n <= 13; n++) begin
            frame_pulse();
            check_val($sformatf("auto_fe%0d", n), {30'd0, pattern_sel}, (n / 3) % 4);
        end
        // now pattern 0, frame_cnt 1

        // ---- hold for 10 frames ----
        hold = 1'b1;
        for (int n = 1; n <= 10; n++) frame_pulse();
        check_val("hold_pattern", {30'd0, pattern_sel}, 32'd0);
        hold = 1'b0;
        frame_pulse();   // cnt 1 -> 2
        check_val("hold_rel1", {30'd0, pattern_sel}, 32'd0);
        frame_pulse();   // cnt 2 -> advance
        check_val("hold_rel2", {30'd0, pattern_sel}, 32'd1);
        pix("white_px", 1'b1, 10'd77, 24'hFFFFFF);

        // ---- manual advance ----
        frame_pulse();   // pattern 1, cnt 1
        @(negedge clk_25) adv_req = 1'b1;
        repeat (6) @(negedge clk_25);
        check_val("man_wait_pat", {30'd0, pattern_sel}, 32'd1);
        check_val("man_wait_ack", {31'd0, adv_ack}, 32'd0);
        frame_pulse();
        check_val("man_pat", {30'd0, pattern_sel}, 32'd2);
        check_val("man_ack_hi", {31'd0, adv_ack}, 32'd1);
        @(negedge clk_25) adv_req = 1'b0;
        #1 check_val("man_ack_still", {31'd0, adv_ack}, 32'd1);
        @(negedge clk_25);
        check_val("man_ack_lo", {31'd0, adv_ack}, 32'd0);
        pix("ramp_col400", 1'b1, 10'd400, 24'h646464);

        // ---- collision: manual pending on the auto-period edge ----
        frame_pulse();   // cnt 1
        frame_pulse();   // cnt 2
        check_val("coll_pre", {30'd0, pattern_sel}, 32'd2);
        @(negedge clk_25) adv_req = 1'b1;
        repeat (3) @(negedge clk_25);
        frame_pulse();
        check_val("coll_pat", {30'd0, pattern_sel}, 32'd3);
        adv_req = 1'b0;
        repeat (2) @(negedge clk_25);
        // checker with frame_cnt 0 proves the counter was cleared
        pix("chk_c32_f0", 1'b1, 10'd32, 24'hFFFFFF);
        pix("chk_c0_f0",  1'b1, 10'd0,  24'h000000);
        frame_pulse();   // cnt 1
        pix("chk_c32_f1", 1'b1, 10'd32, 24'h000000);
        pix("chk_c0_f1",  1'b1, 10'd0,  24'hFFFFFF);
        frame_pulse();   // cnt 2
        check_val("coll_cnt2", {30'd0, pattern_sel}, 32'd3);
        frame_pulse();   // advance, wrap
        check_val("coll_wrap", {30'd0, pattern_sel}, 32'd0);

        // ---- request dropped before the frame edge is still served ----
        @(negedge clk_25) adv_req = 1'b1;
        repeat (3) @(negedge clk_25);
        adv_req = 1'b0;
        repeat (3) @(negedge clk_25);
        check_val("latch_wait", {30'd0, pattern_sel}, 32'd0);
        frame_pulse();
        check_val("latch_pat", {30'd0, pattern_sel}, 32'd1);
        check_val("latch_ack", {31'd0, adv_ack}, 32'd0);

        // ---- asynchronous reset mid-handshake ----
        @(negedge clk_25) adv_req = 1'b1;
        repeat (3) @(negedge clk_25);
        frame_pulse();   // pattern 2, in ACK
        check_val("pre_rst_ack", {31'd0, adv_ack}, 32'd1);
        pix("pre_rst_ramp", 1'b1, 10'd639, 24'h9F9F9F);
        #1 rst = 1'b1;
        #1;
        check_val("arst_rgb", {8'h0, red, green, blue}, 32'd0);
        check_val("arst_pattern", {30'd0, pattern_sel}, 32'd0);
        check_val("arst_ack", {31'd0, adv_ack}, 32'd0);
        @(negedge clk_25);
        adv_req = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk_25);
        frame_pulse();   // cnt 1, no stale request
        check_val("post_rst_pat", {30'd0, pattern_sel}, 32'd0);
        check_val("post_rst_ack", {31'd0, adv_ack}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
